// File: rtl/pdm_stim_pkg.sv
// pdm_stim_pkg: mode encodings, config record and offset-binary helper for pdm_stim_gen
package pdm_stim_pkg;
  localparam int CFG_LEVEL_W = 16;
  localparam int CFG_PATTERN_W = 32;
  typedef enum logic [1:0] {
    MODE_DC      = 2'd0,
    MODE_SQUARE  = 2'd1,
    MODE_PATTERN = 2'd2
  } mode_e;
  typedef struct packed {
    mode_e                         mode;
    logic signed [CFG_LEVEL_W-1:0] level;
    logic [15:0]                   half_period;
    logic [CFG_PATTERN_W-1:0]      pattern;
  } cfg_t;
  function automatic logic [CFG_LEVEL_W-1:0] to_offset_bin(input logic [CFG_LEVEL_W-1:0] v);
    return {~v[CFG_LEVEL_W-1], v[CFG_LEVEL_W-2:0]};
  endfunction
endpackage

// File: rtl/pdm_sd_mod.sv
// pdm_sd_mod: sigma-delta modulator; first-order carry by default, second-order with PDM_STIM_SD2_EN
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : advance one bit period
//   clr        : restart from zero state (applied before a same-cycle tick)
//   x          : signed input sample
//   q          : bit produced by this tick (valid while tick=1)
module pdm_sd_mod
  import pdm_stim_pkg::*;
#(
  parameter int DATA_W = CFG_LEVEL_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] x,
  output logic                     q
);
`ifdef PDM_STIM_SD2_EN
  localparam int IW = DATA_W + 4;
  localparam logic signed [IW-1:0] FS = IW'(1) <<< (DATA_W - 1);
  logic signed [IW-1:0] i1, i2, i1_n, i2_n, fb;
  logic prev;
  always_comb begin
    fb = (!clr && prev) ? FS : -FS;
    i1_n = (clr ? '0 : i1) + IW'(x) - fb;
    i2_n = (clr ? '0 : i2) + i1_n - fb;
    q = !i2_n[IW-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      i1 <= '0;
      i2 <= '0;
      prev <= 1'b0;
    end else if (tick) begin
      i1 <= i1_n;
      i2 <= i2_n;
      prev <= q;
    end else if (clr) begin
      i1 <= '0;
      i2 <= '0;
      prev <= 1'b0;
    end
`else
  logic [DATA_W-1:0] acc;
  logic [DATA_W:0] sum;
  assign sum = {1'b0, acc & {DATA_W{!clr}}} + {1'b0, to_offset_bin(x)};
  assign q = sum[DATA_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (tick) acc <= sum[DATA_W-1:0];
    else if (clr) acc <= '0;
`endif
endmodule

// File: rtl/pdm_stim_gen.sv
// pdm_stim_gen: PDM microphone emulator producing M_CLK/M_DATA from DC, square or pattern sources
//   clk, rst_n          : system clock, asynchronous active-low reset
//   en                  : generator enable; low clears divider, outputs, counter and modulator
//   cfg_valid/cfg_ready : config handshake; accepted config applies at the next bit_tick (or next cycle when en=0)
//   cfg_mode/level/half_period/pattern : config fields (mode 3 behaves as DC)
//   M_CLK, M_DATA       : PDM clock and data; data changes on M_CLK falling
//   bit_tick            : high in the cycle whose closing edge updates M_DATA
//   bit_count           : bits emitted since reset or enable
//   PDM_STIM_SD2_EN     : selects the second-order modulator in pdm_sd_mod
module pdm_stim_gen
  import pdm_stim_pkg::*;
#(
  parameter int DATA_W    = CFG_LEVEL_W,
  parameter int CLK_DIV   = 50,
  parameter int PATTERN_W = CFG_PATTERN_W,
  parameter int CNT_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [1:0]               cfg_mode,
  input  logic signed [DATA_W-1:0] cfg_level,
  input  logic [15:0]              cfg_half_period,
  input  logic [PATTERN_W-1:0]     cfg_pattern,
  output logic                     M_CLK,
  output logic                     M_DATA,
  output logic                     bit_tick,
  output logic [CNT_W-1:0]         bit_count
);
  localparam int HALF = CLK_DIV / 2;
  localparam int DW = $clog2(CLK_DIV);
  localparam int IW = $clog2(PATTERN_W);
  logic [DW-1:0] div_cnt;
  logic [IW-1:0] idx, idx_b;
  logic [15:0] sq_cnt, sq_cnt_b, hp;
  logic sq_neg, sq_neg_b, sq_wrap, apply, clr, sd_q;
  logic signed [DATA_W-1:0] x, lvl;
  cfg_t act, pend, cur;
  assign bit_tick = en && div_cnt == DW'(HALF);
  // The pending config takes effect on the tick itself, so that tick's sample already uses it.
  always_comb begin
    apply = !cfg_ready && (bit_tick || !en);
    cur = apply ? pend : act;
    clr = !en || (apply && pend.mode != act.mode);
    idx_b = clr ? '0 : idx;
    sq_cnt_b = clr ? '0 : sq_cnt;
    sq_neg_b = !clr && sq_neg;
    hp = cur.half_period == '0 ? 16'd1 : cur.half_period;
    sq_wrap = sq_cnt_b >= hp - 16'd1;
    lvl = DATA_W'(cur.level);
    x = (cur.mode == MODE_SQUARE && sq_neg_b)
      ? (lvl == {1'b1, {(DATA_W-1){1'b0}}} ? ~lvl : -lvl) : lvl;
  end
  pdm_sd_mod #(.DATA_W(DATA_W)) u_mod (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (bit_tick),
    .clr  (clr),
    .x    (x),
    .q    (sd_q)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_cnt <= '0;
      M_CLK <= 1'b0;
      M_DATA <= 1'b0;
      bit_count <= '0;
      idx <= '0;
      sq_cnt <= '0;
      sq_neg <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      M_CLK <= 1'b0;
      M_DATA <= 1'b0;
      bit_count <= '0;
      idx <= '0;
      sq_cnt <= '0;
      sq_neg <= 1'b0;
    end else begin
      div_cnt <= div_cnt == DW'(CLK_DIV - 1) ? '0 : div_cnt + 1'b1;
      M_CLK <= div_cnt < DW'(HALF);
      if (bit_tick) begin
        M_DATA <= cur.mode == MODE_PATTERN ? cur.pattern[idx_b] : sd_q;
        bit_count <= bit_count + 1'b1;
        idx <= idx_b == IW'(PATTERN_W - 1) ? '0 : idx_b + 1'b1;
        sq_cnt <= sq_wrap ? '0 : sq_cnt_b + 16'd1;
        sq_neg <= sq_neg_b ^ sq_wrap;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cfg_ready <= 1'b1;
      act <= '0;
      pend <= '0;
    end else if (apply) begin
      act <= pend;
      cfg_ready <= 1'b1;
    end else if (cfg_valid && cfg_ready) begin
      pend <= '{mode: cfg_mode == MODE_PATTERN ? MODE_PATTERN : cfg_mode == MODE_SQUARE ? MODE_SQUARE : MODE_DC,
                level: CFG_LEVEL_W'(cfg_level),
                half_period: cfg_half_period,
                pattern: CFG_PATTERN_W'(cfg_pattern)};
      cfg_ready <= 1'b0;
    end
endmodule

// File: doc/pdm_stim_gen.md
Name: pdm_stim_gen

Overview:
- Synthesizable PDM microphone emulator for the spectrum analyzer path.
- Generates M_CLK and a modulated M_DATA bitstream in place of the physical microphone, so the decimation/FFT chain can be exercised on-board and in simulation with known spectra.
- Source modes: DC level, square wave, or replay of a programmable bit pattern. All modes except pattern pass through a sigma-delta modulator.

Parameters:
- DATA_W, 16, signed sample width driving the modulator.
- CLK_DIV, 50, clk cycles per PDM bit period; even, >=4.
- PATTERN_W, 32, length of replay pattern register.
- CNT_W, 32, width of emitted-bit counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  generator enable.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  configuration accept.
- cfg_mode  in  2  0=DC, 1=square, 2=pattern, 3=reserved (treated as DC).
- cfg_level  in  DATA_W  signed DC level / square amplitude.
- cfg_half_period  in  16  square half period in bit periods; 0 treated as 1.
- cfg_pattern  in  PATTERN_W  replay bits, LSB first.
- M_CLK  out  1  PDM clock to consumer.
- M_DATA  out  1  PDM data.
- bit_tick  out  1  one-cycle pulse when M_DATA updates.
- bit_count  out  CNT_W  bits emitted since reset or enable, wraps.

Behaviour:
- Reset values: M_CLK=0, M_DATA=0, bit_tick=0, bit_count=0, cfg_ready=1. Active config: mode=DC, level=0, pattern=0. Modulator state 0, divider 0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps while en=1.
  - M_CLK=1 for div_cnt < CLK_DIV/2, registered.
  - At div_cnt==CLK_DIV/2 (M_CLK falling), bit_tick pulses and M_DATA, bit_count and modulator state update in the same edge. Data is therefore stable around every M_CLK rise.
- en=0:
  - div_cnt, M_CLK, M_DATA, bit_count and modulator state are cleared next cycle.
  - Pending config is kept.
  - Re-enable restarts from div_cnt=0.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready. Fields are captured into a pending register and cfg_ready drops.
  - The pending config is applied at the next bit_tick, before that tick's sample is computed; cfg_ready returns to 1 the cycle after.
  - With en=0, the pending config is applied on the next cycle.
  - If the mode changes, the modulator state, square phase counter and pattern index clear on apply. A same-mode update keeps all of them.
- Sample source (per bit_tick):
  - DC: x=cfg_level.
  - Square: x=+level for half_period ticks, then -level (saturating at most-negative) for half_period ticks, starting positive.
  - Pattern: M_DATA=pattern[idx], idx wraps PATTERN_W-1 -> 0; modulator bypassed.
- First-order modulator:
  - u = x with MSB inverted (offset binary).
  - {carry, acc} = acc + u over DATA_W+1 bits; M_DATA=carry.
  - Density of ones is exactly u / 2^DATA_W over any 2^DATA_W ticks.
- Simultaneous events: cfg transfer in the same cycle as bit_tick is not applied until the following bit_tick. Reset overrides everything asynchronously, at any point.

Optional Feature:
- Macro PDM_STIM_SD2_EN.
- Defined: second-order modulator replaces first-order in DC/square modes.
  - Signed integrators i1, i2 of DATA_W+4 bits; FS = 2^(DATA_W-1).
  - fb = +FS if the previous bit was 1, else -FS.
  - i1 += x - fb; i2 += i1 - fb; M_DATA = (i2 >= 0).
  - Both integrators clear on mode change, reset and en=0.
- Undefined: first-order carry modulator only; integrator logic is absent.

Decomposition:
- Package pdm_stim_pkg holds:
  - mode encodings MODE_DC, MODE_SQUARE, MODE_PATTERN;
  - offset-binary conversion function;
  - a config struct typedef for mode, level, half_period and pattern.
- One natural sub-module: pdm_sd_mod, the modulator (sample in, tick in, bit out, clear in). It carries the first- and second-order variants under the macro.
- Divider, handshake and sources stay in the top.

Test Plan:
- Reset/idle: rst_n=0 with en=1 and clk running -> M_CLK=0, M_DATA=0, cfg_ready=1, bit_count=0. Release with en=1 -> first bit_tick at cycle CLK_DIV/2.
- DC mid-scale: DATA_W=16, level=0 -> M_DATA reads 0,1,0,1,...; exactly 512 ones in 1024 ticks (first-order build).
- DC +half-scale: level=16'h4000 -> exactly 768 ones in 1024 ticks. level=16'h8000 -> all zeros.
- Pattern: pattern=32'h0000_00B5 -> bits 1,0,1,0,1,1,0,1 then 24 zeros, repeating; bit_count=64 after two cycles of the pattern.
- Mid-bit config: offer cfg at div_cnt=3 while in DC -> cfg_ready low until the next bit_tick. The new mode is visible on that tick's M_DATA; cfg_ready=1 the next cycle.
- Square plus async reset: level=16'h4000, half_period=8 -> ones density 6/8 per positive half, 2/8 per negative half. Assert rst_n mid-bit -> all outputs return to reset values the same cycle, without waiting for a clock edge.
